indicator_sched: RTL

//  Time-shares the 4-digit seven-segment display between N status sources
//  (floppy track, HDD LBA, error code, ctrl message ...).

---
 rtl/indicator_sched_pkg.sv | 21 ++
 rtl/indicator_sched_if.sv | 14 +
 rtl/indicator_sched_rr_pick.sv | 26 ++
 rtl/indicator_sched.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/indicator_sched_pkg.sv
// Shared constants for the seven-segment indicator scheduler: FSM encodings,
// default timing parameters and a small index helper.
package indicator_sched_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  localparam int DEF_N        = 4;
  localparam int DEF_TICK_DIV = 28000;
  localparam int DEF_HOLD     = 8;
  localparam int DEF_MIN_HOLD = 2;
  localparam int DEF_IDLE     = 32;

  localparam int VAL_W = 16;
  localparam int SRC_W = 3;

  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/indicator_sched_if.sv
// Source-side request/acknowledge bus plus the display outputs of the scheduler.
interface indicator_sched_if #(
  parameter int N = 4
) ();
  logic [N-1:0]    src_req;
  logic [16*N-1:0] src_val;
  logic [N-1:0]    src_ack;
  logic [15:0]     disp_val;
  logic [2:0]      disp_src;
  logic            disp_valid;

  modport master (output src_req, src_val, input src_ack, disp_val, disp_src, disp_valid);
  modport slave  (input src_req, src_val, output src_ack, disp_val, disp_src, disp_valid);
endinterface

// File: rtl/indicator_sched_rr_pick.sv
// Combinational round-robin select: first pending source after 'last', wrapping at N.
module indicator_sched_rr_pick
  import indicator_sched_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]     pend_i,
  input  logic [SRC_W-1:0] last_i,
  output logic [SRC_W-1:0] idx_o,
  output logic             any_o
);
  logic [2*N-1:0] rot;

  always_comb begin
    // Rotate so bit 0 corresponds to last+1; the doubled vector handles wrap.
    rot   = {pend_i, pend_i} >> (int'(last_i) + 1);
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && rot[k]) begin
        any_o = 1'b1;
        idx_o = SRC_W'(wrap_idx(int'(last_i) + 1, k, N));
      end
    end
  end
endmodule

// File: rtl/indicator_sched.sv
// Time-shares the 4-digit display between N sources: minimum dwell, round-robin
// rotation, source-0 pre-emption and blanking after a quiet period.
module indicator_sched
  import indicator_sched_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int HOLD     = DEF_HOLD,
  parameter int MIN_HOLD = DEF_MIN_HOLD,
  parameter int IDLE     = DEF_IDLE
) (
  input  logic              clk,
  input  logic              rst_n,
  indicator_sched_if.slave  bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD);
  localparam int IW = $clog2(IDLE);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD - 1);
  localparam logic [HW-1:0] HOLD_MIN  = HW'(MIN_HOLD);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE - 1);

  logic [0:0]       state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [VAL_W-1:0] pval_q [N];
  logic [VAL_W-1:0] pval_d [N];
  logic [VAL_W-1:0] disp_val_q, disp_val_d;
  logic [SRC_W-1:0] disp_src_q, disp_src_d;
  logic             disp_valid_q, disp_valid_d;
  logic [N-1:0]     ack_q, ack_d;

  logic             tick, show, preempt, rotate, start, grant, direct, blank, rr_any;
  logic [SRC_W-1:0] rr_idx, gidx;
  logic [N-1:0]     is_cur;
  logic [VAL_W-1:0] direct_val;

  assign tick = (presc_q == PRESC_MAX);

  indicator_sched_rr_pick #(.N(N)) u_rr (
    .pend_i (pend_q),
    .last_i (disp_src_q),
    .idx_o  (rr_idx),
    .any_o  (rr_any)
  );

  always_comb begin
    is_cur     = '0;
    direct_val = '0;
    for (int i = 0; i < N; i++) begin
      is_cur[i] = (SRC_W'(i) == disp_src_q);
      if (is_cur[i]) direct_val = bus.src_val[VAL_W*i +: VAL_W];
    end
    show    = (state_q == ST_SHOW);
    // Pre-emption is checked every cycle; rotation only on dwell ticks.
    preempt = show && pend_q[0] && (disp_src_q != '0) && (hold_q >= HOLD_MIN);
    rotate  = show && tick && (hold_q == HOLD_MAX) && rr_any;
    start   = !show && rr_any;
    grant   = preempt || rotate || start;
    gidx    = preempt ? '0 : rr_idx;
    direct  = show && !grant && |(bus.src_req & is_cur);
    blank   = show && !direct && !rr_any && tick && (idle_q == IDLE_MAX);
  end

  always_comb begin
    state_d      = state_q;
    presc_d      = tick ? '0 : presc_q + 1'b1;
    hold_d       = hold_q;
    idle_d       = idle_q;
    pend_d       = pend_q;
    pval_d       = pval_q;
    disp_val_d   = disp_val_q;
    disp_src_d   = disp_src_q;
    disp_valid_d = disp_valid_q;
    ack_d        = '0;

    if (show && tick) begin
      if (hold_q != HOLD_MAX)                 hold_d = hold_q + 1'b1;
      else if (!rr_any && idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
    end
    if (direct) begin
      disp_val_d = direct_val;
      hold_d     = '0;
      idle_d     = '0;
    end
    if (blank) begin
      state_d      = ST_IDLE;
      disp_valid_d = 1'b0;
    end
    if (grant) begin
      state_d      = ST_SHOW;
      disp_valid_d = 1'b1;
      disp_src_d   = gidx;
      hold_d       = '0;
      idle_d       = '0;
      for (int i = 0; i < N; i++) begin
        if (SRC_W'(i) == gidx) begin
          disp_val_d = pval_q[i];
          pend_d[i]  = 1'b0;
          ack_d[i]   = 1'b1;
        end
      end
    end
    // Capture comes last so a request coinciding with its own grant stays pending.
    for (int i = 0; i < N; i++) begin
      if (bus.src_req[i] && !(direct && is_cur[i])) begin
        pend_d[i] = 1'b1;
        pval_d[i] = bus.src_val[VAL_W*i +: VAL_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      hold_q       <= '0;
      idle_q       <= '0;
      pend_q       <= '0;
      pval_q       <= '{default: '0};
      disp_val_q   <= '0;
      disp_src_q   <= '0;
      disp_valid_q <= 1'b0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      hold_q       <= hold_d;
      idle_q       <= idle_d;
      pend_q       <= pend_d;
      pval_q       <= pval_d;
      disp_val_q   <= disp_val_d;
      disp_src_q   <= disp_src_d;
      disp_valid_q <= disp_valid_d;
      ack_q        <= ack_d;
    end
  end

  assign bus.src_ack    = ack_q;
  assign bus.disp_val   = disp_val_q;
  assign bus.disp_src   = disp_src_q;
  assign bus.disp_valid = disp_valid_q;
endmodule
